id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the execute-stage ALU. Captures decoded operations
//  (ALU control, register operands, immediate, destination) under a valid/ready handshake.
//  Drives the ALU's alu_control, a and b. Resolves RAW hazards against EX/MEM and MEM/WB
//  by forwarding or by interlock.
// PARAMETERS
//  WIDTH       32  data width of operands and the result buses
//  CTRL_WIDTH  3   ALU control width (000 ADD, 001 SUB ... 111 SRL)
//  REG_AW      5   register index width; index 0 is hard-wired zero
//  CNT_WIDTH   16  width of the saturating stall counter
// PORTS
//  clk             in   1           single clock, rising edge
//  rst_n           in   1           asynchronous, active-low reset
//  in_valid        in   1           decode stage presents an op
//  in_ready        out  1           stage accepts op this cycle
//  in_alu_control  in   CTRL_WIDTH  decoded ALU op
//  in_rs1/in_rs2   in   REG_AW      source register indices
//  in_rs1_data     in   WIDTH       register file read data, port 1
//  in_rs2_data     in   WIDTH       register file read data, port 2
//  in_imm          in   WIDTH       sign-extended immediate
//  in_use_imm      in   1           1: b = immediate
//  in_rd           in   REG_AW      destination index
//  in_reg_write    in   1           op writes rd
//  flush           in   1           kill held op (branch redirect)
//  ex_ready        in   1           execute stage consumes op
//  exmem_rd/_reg_write/_result   in  REG_AW/1/WIDTH  EX/MEM writeback info
//  memwb_rd/_reg_write/_result   in  REG_AW/1/WIDTH  MEM/WB writeback info
//  out_valid       out  1           alu_control/a/b valid
//  alu_control     out  CTRL_WIDTH  to ALU
//  a, b            out  WIDTH       ALU operands
//  out_rd          out  REG_AW      destination, passed downstream
//  out_reg_write   out  1           write enable, passed downstream
//  stall_count     out  CNT_WIDTH   interlock-stall cycles; saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, all held fields 0, stall_count=0.
//    As a result, alu_control=000, a=b=0, out_rd=0, out_reg_write=0.
//  - FSM: EMPTY (out_valid=0) / FULL (out_valid=1).
//    EMPTY->FULL on accept. FULL->EMPTY on ex_ready & ~accept. FULL->FULL on accept or hold.
//  - in_ready = (~out_valid | ex_ready) & ~hazard_stall; accept = in_valid & in_ready.
//  - Latency 1: op accepted at edge N is presented on outputs after edge N.
//    Full throughput with no bubbles.
//  - Hold: FULL & ~ex_ready keeps every registered field stable.
//  - flush has priority: the next edge forces out_valid=0 and drops any op accepted that cycle.
//    stall_count is unaffected by flush.
//  - b = held_use_imm ? held_imm : rs2 operand. Immediate is never forwarded.
//  - Register index 0 never matches a writeback and never causes forwarding or interlock.
//  - stall_count increments on every cycle with in_valid & hazard_stall. Holds at max.
// CONFIGURATION
//  EX_FORWARD_EN defined: hazard_stall=0.
//    a and rs2 operand are combinationally muxed from held data.
//    EX/MEM result takes priority over MEM/WB result when both match the held rs index with reg_write=1.
//    Otherwise the held register file data is used.
//  EX_FORWARD_EN undefined: no forwarding muxes; a and b come directly from held data.
//    hazard_stall=1 while in_rs1 or in_rs2 (non-zero) equals the rd of a pending writer.
//    Pending writers: the held op (when FULL), EX/MEM, or MEM/WB, each with reg_write=1.
//    stall_count then counts stall cycles.
// STRUCTURE
//  Shared package: ALU op encodings (ALU_ADD..ALU_SRL), default widths, REG_ZERO constant.
//  One sub-module: id_ex_fwd_mux, the per-operand 3:1 priority forward select.
//  It is instantiated twice under EX_FORWARD_EN.
// TESTING
//  1. Reset mid-FULL with ex_ready=0 -> out_valid=0, a=b=0, stall_count=0 immediately (async).
//  2. Back-to-back ADD ops, ex_ready=1 -> one op/cycle, in_ready constant 1, 1-cycle latency.
//  3. ex_ready=0 for 3 cycles while FULL -> in_ready=0, outputs stable, then drain in order.
//  4. Forwarding on, held rs1=5: exmem_rd=5 (result 0xAAAA) and memwb_rd=5 (result 0x5555) -> a=0xAAAA.
//     With rs1=0 and exmem_rd=0 -> a=held data.
//  5. Forwarding off: held op rd=3 and in_rs2=3 -> in_ready=0, stall_count +1/cycle until the writer retires.
//  6. flush and accept in the same cycle -> out_valid=0 next cycle; the accepted op is never presented.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op encodings, default widths and stage states.
package id_ex_stage_pkg;

    localparam int WIDTH_DEF      = 32;
    localparam int CTRL_WIDTH_DEF = 3;
    localparam int REG_AW_DEF     = 5;
    localparam int CNT_WIDTH_DEF  = 16;

    localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Per-operand forward select: EX/MEM result beats MEM/WB result beats register file data.
module id_ex_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [WIDTH-1:0]  exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [WIDTH-1:0]  memwb_result,
    output logic [WIDTH-1:0]  data
);

    always_comb begin
        data = rs_data;
        // r0 is hard-wired zero, so a writeback to it must never be picked up
        if (rs != REG_AW'(REG_ZERO)) begin
            if (exmem_reg_write && (exmem_rd == rs)) begin
                data = exmem_result;
            end else if (memwb_reg_write && (memwb_rd == rs)) begin
                data = memwb_result;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with RAW hazard handling.
// Build option EX_FORWARD_EN: forward EX/MEM and MEM/WB results; otherwise interlock on pending writers.
//
// state    | meaning
// ST_EMPTY | no op held, out_valid=0
// ST_FULL  | op held and presented to the ALU, out_valid=1
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_alu_control,
    input  logic [REG_AW-1:0]     in_rs1,
    input  logic [REG_AW-1:0]     in_rs2,
    input  logic [WIDTH-1:0]      in_rs1_data,
    input  logic [WIDTH-1:0]      in_rs2_data,
    input  logic [WIDTH-1:0]      in_imm,
    input  logic                  in_use_imm,
    input  logic [REG_AW-1:0]     in_rd,
    input  logic                  in_reg_write,
    input  logic                  flush,
    input  logic                  ex_ready,
    input  logic [REG_AW-1:0]     exmem_rd,
    input  logic                  exmem_reg_write,
    input  logic [WIDTH-1:0]      exmem_result,
    input  logic [REG_AW-1:0]     memwb_rd,
    input  logic                  memwb_reg_write,
    input  logic [WIDTH-1:0]      memwb_result,
    output logic                  out_valid,
    output logic [CTRL_WIDTH-1:0] alu_control,
    output logic [WIDTH-1:0]      a,
    output logic [WIDTH-1:0]      b,
    output logic [REG_AW-1:0]     out_rd,
    output logic                  out_reg_write,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    stage_state_e state_q, state_d;

    logic                  accept;
    logic                  load;
    logic                  hazard_stall;

    logic [REG_AW-1:0]     held_rs1;
    logic [REG_AW-1:0]     held_rs2;
    logic [WIDTH-1:0]      held_rs1_data;
    logic [WIDTH-1:0]      held_rs2_data;
    logic [WIDTH-1:0]      held_imm;
    logic                  held_use_imm;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (~out_valid | ex_ready) & ~hazard_stall;
    assign accept    = in_valid & in_ready;
    // a flushed cycle still completes the handshake, but the op is discarded
    assign load      = accept & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (accept) begin
                        state_d = ST_FULL;
                    end else if (ex_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control   <= '0;
            held_rs1      <= '0;
            held_rs2      <= '0;
            held_rs1_data <= '0;
            held_rs2_data <= '0;
            held_imm      <= '0;
            held_use_imm  <= 1'b0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else if (load) begin
            alu_control   <= in_alu_control;
            held_rs1      <= in_rs1;
            held_rs2      <= in_rs2;
            held_rs1_data <= in_rs1_data;
            held_rs2_data <= in_rs2_data;
            held_imm      <= in_imm;
            held_use_imm  <= in_use_imm;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (in_valid && hazard_stall && (stall_count != {CNT_WIDTH{1'b1}})) begin
            stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

`ifdef EX_FORWARD_EN

    logic [WIDTH-1:0] rs2_operand;

    assign hazard_stall = 1'b0;

    id_ex_fwd_mux #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_fwd_a (
        .rs              (held_rs1),
        .rs_data         (held_rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .data            (a)
    );

    id_ex_fwd_mux #(
        .WIDTH  (WIDTH),
        .REG_AW (REG_AW)
    ) u_fwd_b (
        .rs              (held_rs2),
        .rs_data         (held_rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .data            (rs2_operand)
    );

    // the immediate is a decode-time constant and is never forwarded
    assign b = held_use_imm ? held_imm : rs2_operand;

`else

    logic rs1_hit;
    logic rs2_hit;
    logic unused_fwd;

    // pending writers: the op held here, EX/MEM and MEM/WB
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        if (in_rs1 != REG_AW'(REG_ZERO)) begin
            rs1_hit = (out_valid && out_reg_write && (out_rd == in_rs1))
                   || (exmem_reg_write && (exmem_rd == in_rs1))
                   || (memwb_reg_write && (memwb_rd == in_rs1));
        end
        if (in_rs2 != REG_AW'(REG_ZERO)) begin
            rs2_hit = (out_valid && out_reg_write && (out_rd == in_rs2))
                   || (exmem_reg_write && (exmem_rd == in_rs2))
                   || (memwb_reg_write && (memwb_rd == in_rs2));
        end
    end

    assign hazard_stall = rs1_hit | rs2_hit;

    assign a = held_rs1_data;
    assign b = held_use_imm ? held_imm : held_rs2_data;

    assign unused_fwd = ^{exmem_result, memwb_result, held_rs1, held_rs2};

`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (stall counter narrowed to 4 bits to reach saturation).
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int WIDTH      = 32;
    localparam int CTRL_WIDTH = 3;
    localparam int REG_AW     = 5;
    localparam int CNT_WIDTH  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [CTRL_WIDTH-1:0] in_alu_control;
    logic [REG_AW-1:0]     in_rs1;
    logic [REG_AW-1:0]     in_rs2;
    logic [WIDTH-1:0]      in_rs1_data;
    logic [WIDTH-1:0]      in_rs2_data;
    logic [WIDTH-1:0]      in_imm;
    logic                  in_use_imm;
    logic [REG_AW-1:0]     in_rd;
    logic                  in_reg_write;
    logic                  flush;
    logic                  ex_ready;
    logic [REG_AW-1:0]     exmem_rd;
    logic                  exmem_reg_write;
    logic [WIDTH-1:0]      exmem_result;
    logic [REG_AW-1:0]     memwb_rd;
    logic                  memwb_reg_write;
    logic [WIDTH-1:0]      memwb_result;
    logic                  out_valid;
    logic [CTRL_WIDTH-1:0] alu_control;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [REG_AW-1:0]     out_rd;
    logic                  out_reg_write;
    logic [CNT_WIDTH-1:0]  stall_count;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    id_ex_stage #(
        .WIDTH      (WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .REG_AW     (REG_AW),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_alu_control  (in_alu_control),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_use_imm      (in_use_imm),
        .in_rd           (in_rd),
        .in_reg_write    (in_reg_write),
        .flush           (flush),
        .ex_ready        (ex_ready),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .out_valid       (out_valid),
        .alu_control     (alu_control),
        .a               (a),
        .b               (b),
        .out_rd          (out_rd),
        .out_reg_write   (out_reg_write),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid        = 1'b0;
        in_alu_control  = '0;
        in_rs1          = '0;
        in_rs2          = '0;
        in_rs1_data     = '0;
        in_rs2_data     = '0;
        in_imm          = '0;
        in_use_imm      = 1'b0;
        in_rd           = '0;
        in_reg_write    = 1'b0;
        flush           = 1'b0;
        exmem_rd        = '0;
        exmem_reg_write = 1'b0;
        exmem_result    = '0;
        memwb_rd        = '0;
        memwb_reg_write = 1'b0;
        memwb_result    = '0;
    endtask

    task automatic drive_op(input logic [2:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                            input logic use_imm, input logic [4:0] rd, input logic rw);
        in_valid       = 1'b1;
        in_alu_control = ctrl;
        in_rs1         = rs1;
        in_rs2         = rs2;
        in_rs1_data    = d1;
        in_rs2_data    = d2;
        in_imm         = imm;
        in_use_imm     = use_imm;
        in_rd          = rd;
        in_reg_write   = rw;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ex_ready = 1'b1;
        set_idle();
        #1 rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL reset_a: got %h want 0", a); end
        checks++; if (b !== 32'h0) begin errors++; $display("FAIL reset_b: got %h want 0", b); end
        checks++; if (stall_count !== 4'h0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, imm, exp_b;
        logic        ui;
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d1 = 32'h100 + 32'(i);
            d2 = 32'h200 + 32'(i);
            imm = 32'hFFFF_FFF0 + 32'(i);
            ui = (i == 2);
            exp_b = ui ? imm : d2;
            drive_op(ALU_ADD, 5'd1, 5'd2, d1, d2, imm, ui, 5'(10 + i), 1'b1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            checks++; if (a !== d1) begin errors++; $display("FAIL b2b_a[%0d]: got %h want %h", i, a, d1); end
            checks++; if (b !== exp_b) begin errors++; $display("FAIL b2b_b[%0d]: got %h want %h", i, b, exp_b); end
            checks++; if (out_rd !== 5'(10 + i)) begin errors++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", i, out_rd, 10 + i); end
            checks++; if (alu_control !== ALU_ADD) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %b want 000", i, alu_control); end
        end
        set_idle();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_hold();
        ex_ready = 1'b0;
        drive_op(ALU_XOR, 5'd3, 5'd4, 32'hA1A1_0001, 32'hA2A2_0002, 32'h0, 1'b0, 5'd12, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_accept_a: got %b want 1", in_ready); end
        tick();
        drive_op(ALU_SLL, 5'd6, 5'd7, 32'hB1B1_0001, 32'hB2B2_0002, 32'h0, 1'b0, 5'd13, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", k, out_valid); end
            checks++; if (a !== 32'hA1A1_0001) begin errors++; $display("FAIL hold_a[%0d]: got %h want a1a10001", k, a); end
            checks++; if (b !== 32'hA2A2_0002) begin errors++; $display("FAIL hold_b[%0d]: got %h want a2a20002", k, b); end
            checks++; if (out_rd !== 5'd12) begin errors++; $display("FAIL hold_rd[%0d]: got %0d want 12", k, out_rd); end
            checks++; if (alu_control !== ALU_XOR) begin errors++; $display("FAIL hold_ctrl[%0d]: got %b want 100", k, alu_control); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", in_ready); end
        tick();
        checks++; if (a !== 32'hB1B1_0001) begin errors++; $display("FAIL hold_next_a: got %h want b1b10001", a); end
        checks++; if (out_rd !== 5'd13) begin errors++; $display("FAIL hold_next_rd: got %0d want 13", out_rd); end
        checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL hold_next_rw: got %b want 0", out_reg_write); end
        set_idle();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b1;
        drive_op(ALU_OR, 5'd1, 5'd2, 32'hF1, 32'hF2, 32'h0, 1'b0, 5'd9, 1'b1);
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_valid: got %b want 0", out_valid); end
        set_idle();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_never_presented: got %b want 0", out_valid); end
        ex_ready = 1'b0;
        drive_op(ALU_AND, 5'd1, 5'd2, 32'hC1, 32'hC2, 32'h0, 1'b0, 5'd9, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_full_setup: got %b want 1", out_valid); end
        set_idle();
        flush = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_held: got %b want 0", out_valid); end
        flush = 1'b0;
        ex_ready = 1'b1;
    endtask

`ifdef EX_FORWARD_EN
    task automatic test_forward();
        ex_ready = 1'b1;
        drive_op(ALU_ADD, 5'd5, 5'd6, 32'h1111, 32'h2222, 32'h0, 1'b0, 5'd9, 1'b1);
        tick();
        set_idle();
        ex_ready = 1'b0;
        exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 32'hAAAA;
        memwb_rd = 5'd5; memwb_reg_write = 1'b1; memwb_result = 32'h5555;
        #1;
        checks++; if (a !== 32'hAAAA) begin errors++; $display("FAIL fwd_exmem_prio: got %h want aaaa", a); end
        exmem_reg_write = 1'b0;
        #1;
        checks++; if (a !== 32'h5555) begin errors++; $display("FAIL fwd_memwb: got %h want 5555", a); end
        memwb_reg_write = 1'b0;
        #1;
        checks++; if (a !== 32'h1111) begin errors++; $display("FAIL fwd_none: got %h want 1111", a); end
        memwb_rd = 5'd6; memwb_reg_write = 1'b1; memwb_result = 32'h6666;
        #1;
        checks++; if (b !== 32'h6666) begin errors++; $display("FAIL fwd_b_memwb: got %h want 6666", b); end
        exmem_rd = 5'd6; exmem_reg_write = 1'b1; exmem_result = 32'h7777;
        #1;
        checks++; if (b !== 32'h7777) begin errors++; $display("FAIL fwd_b_exmem: got %h want 7777", b); end
        set_idle();
        ex_ready = 1'b1;
        drive_op(ALU_SUB, 5'd0, 5'd6, 32'h0123, 32'h2222, 32'h0ABC, 1'b1, 5'd4, 1'b1);
        tick();
        set_idle();
        ex_ready = 1'b0;
        exmem_rd = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'h0BAD;
        memwb_rd = 5'd6; memwb_reg_write = 1'b1; memwb_result = 32'h6666;
        #1;
        checks++; if (a !== 32'h0123) begin errors++; $display("FAIL fwd_r0: got %h want 0123", a); end
        checks++; if (b !== 32'h0ABC) begin errors++; $display("FAIL fwd_imm: got %h want 0abc", b); end
        ex_ready = 1'b1;
        drive_op(ALU_ADD, 5'd4, 5'd6, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fwd_no_stall: got %b want 1", in_ready); end
        tick();
        checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL fwd_stall_count: got %0d want %0d", stall_count, exp_stall); end
        set_idle();
        tick();
    endtask
`else
    task automatic test_interlock();
        set_idle();
        ex_ready = 1'b0;
        checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL lock_start: got %0d want %0d", stall_count, exp_stall); end
        drive_op(ALU_ADD, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 5'd3, 1'b1);
        tick();
        drive_op(ALU_SUB, 5'd1, 5'd3, 32'h0B01, 32'h0B02, 32'h0, 1'b0, 5'd8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lock_in_ready[%0d]: got %b want 0", k, in_ready); end
            tick();
            exp_stall++;
            checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL lock_count[%0d]: got %0d want %0d", k, stall_count, exp_stall); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lock_held_writer: got %b want 0", in_ready); end
        tick();
        exp_stall++;
        checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL lock_count_retire: got %0d want %0d", stall_count, exp_stall); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_retired: got %b want 0", out_valid); end
        exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h33;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lock_exmem: got %b want 0", in_ready); end
        tick();
        exp_stall++;
        exmem_reg_write = 1'b0;
        memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h33;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lock_memwb: got %b want 0", in_ready); end
        tick();
        exp_stall++;
        checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL lock_count_wb: got %0d want %0d", stall_count, exp_stall); end
        memwb_reg_write = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lock_clear: got %b want 1", in_ready); end
        tick();
        checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL lock_count_hold: got %0d want %0d", stall_count, exp_stall); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lock_accept_valid: got %b want 1", out_valid); end
        checks++; if (b !== 32'h0B02) begin errors++; $display("FAIL lock_b: got %h want 00000b02", b); end
        checks++; if (out_rd !== 5'd8) begin errors++; $display("FAIL lock_rd: got %0d want 8", out_rd); end
        set_idle();
        ex_ready = 1'b0;
        exmem_rd = 5'd1; exmem_reg_write = 1'b1; exmem_result = 32'hDEAD_0001;
        #1;
        checks++; if (a !== 32'h0B01) begin errors++; $display("FAIL lock_no_fwd: got %h want 00000b01", a); end
        ex_ready = 1'b1;
        exmem_rd = 5'd0;
        drive_op(ALU_ADD, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lock_r0: got %b want 1", in_ready); end
        tick();
        set_idle();
        tick();
    endtask

    task automatic test_stall_saturate();
        set_idle();
        ex_ready = 1'b1;
        exmem_rd = 5'd7; exmem_reg_write = 1'b1; exmem_result = 32'h77;
        in_rs1 = 5'd7;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sat_hazard: got %b want 0", in_ready); end
        tick();
        checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL sat_no_valid: got %0d want %0d", stall_count, exp_stall); end
        in_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
            checks++; if (stall_count !== 4'(exp_stall)) begin errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", k, stall_count, exp_stall); end
        end
        set_idle();
        tick();
    endtask
`endif

    task automatic test_async_reset();
        set_idle();
        ex_ready = 1'b0;
        drive_op(ALU_SRL, 5'd1, 5'd2, 32'h77, 32'h88, 32'h0, 1'b0, 5'd5, 1'b1);
        tick();
        set_idle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_setup: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", out_valid); end
        checks++; if (a !== 32'h0) begin errors++; $display("FAIL areset_a: got %h want 0", a); end
        checks++; if (b !== 32'h0) begin errors++; $display("FAIL areset_b: got %h want 0", b); end
        checks++; if (stall_count !== 4'h0) begin errors++; $display("FAIL areset_stall: got %0d want 0", stall_count); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL areset_rd: got %0d want 0", out_rd); end
        checks++; if (out_reg_write !== 1'b0) begin errors++; $display("FAIL areset_rw: got %b want 0", out_reg_write); end
        checks++; if (alu_control !== 3'b000) begin errors++; $display("FAIL areset_ctrl: got %b want 000", alu_control); end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
`ifdef EX_FORWARD_EN
        test_forward();
`else
        test_interlock();
        test_stall_saturate();
`endif
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
